// File: rtl/fdivider.sv
// fdivider: IEEE-754 single-precision divider, restoring radix-2, fixed 30-edge latency.
// Define FDIVIDER_DBZ_EN to add the divide-by-zero output flag dbz.
module fdivider (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] z,
  output logic        out_valid,
`ifdef FDIVIDER_DBZ_EN
  output logic        dbz,
`endif
  input  logic        out_ready
);
  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORM, ROUND, DONE} state_t;
  state_t r_state, w_next;
  logic               r_in_ready;
  logic        [31:0] r_a, r_b, r_z, r_spec_z;
  logic               r_s, r_spec, r_st;
  logic signed [9:0]  r_exp;
  logic        [23:0] r_mb;
  logic        [24:0] r_rem;
  logic        [25:0] r_q;
  logic        [22:0] r_mant;
  logic        [4:0]  r_cnt;
  logic        [7:0]  w_ea, w_eb;
  logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_nan, w_spec, w_ge, w_up;
  logic        [31:0] w_spec_z, w_pack;
  logic        [24:0] w_rem_n, w_sum;
  assign w_ea     = r_a[30:23];
  assign w_eb     = r_b[30:23];
  assign w_a_zero = w_ea == 8'd0;
  assign w_b_zero = w_eb == 8'd0;
  assign w_a_inf  = (w_ea == 8'hFF) && (r_a[22:0] == 23'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (r_b[22:0] == 23'd0);
  assign w_nan    = ((w_ea == 8'hFF) && (r_a[22:0] != 23'd0)) || ((w_eb == 8'hFF) && (r_b[22:0] != 23'd0))
                  || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf);
  assign w_spec   = w_nan || w_a_inf || w_b_inf || w_a_zero || w_b_zero;
  // Special-case priority: NaN, then infinity (x/0, inf/x), then zero (0/x, x/inf)
  assign w_spec_z = w_nan ? 32'h7FC00000 : (w_a_inf || w_b_zero) ? {r_a[31] ^ r_b[31], 8'hFF, 23'd0}
                  : {r_a[31] ^ r_b[31], 31'd0};
  assign w_ge     = r_rem >= {1'b0, r_mb};
  assign w_rem_n  = w_ge ? r_rem - {1'b0, r_mb} : r_rem;
  assign w_up     = r_q[1] & (r_q[0] | r_st | r_q[2]);
  assign w_sum    = {1'b0, r_q[25:2]} + {24'd0, w_up};
  assign w_pack   = r_spec ? r_spec_z : (r_exp >= 10'sd255) ? {r_s, 8'hFF, 23'd0}
                  : (r_exp <= 10'sd0) ? {r_s, 31'd0} : {r_s, r_exp[7:0], r_mant};
  assign in_ready  = r_in_ready;
  assign out_valid = r_state == DONE;
  assign z         = r_z;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (in_valid && r_in_ready) ? UNPACK : IDLE;
      UNPACK:  w_next = DIVIDE;
      DIVIDE:  w_next = (r_cnt == 5'd25) ? NORM : DIVIDE;
      NORM:    w_next = ROUND;
      ROUND:   w_next = r_cnt[0] ? DONE : ROUND;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
`ifdef FDIVIDER_DBZ_EN
  logic r_dbz;
  assign dbz = (r_state == DONE) & r_dbz;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_dbz <= 1'b0;
    else if (r_state == UNPACK) r_dbz <= w_b_zero & ~w_a_zero & (w_ea != 8'hFF);
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_ready <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_z        <= '0;
      r_spec_z   <= '0;
      r_s        <= 1'b0;
      r_spec     <= 1'b0;
      r_st       <= 1'b0;
      r_exp      <= '0;
      r_mb       <= '0;
      r_rem      <= '0;
      r_q        <= '0;
      r_mant     <= '0;
      r_cnt      <= '0;
    end else begin
      r_in_ready <= w_next == IDLE;
      case (r_state)
        IDLE: if (in_valid && r_in_ready) begin
          r_a <= a;
          r_b <= b;
        end
        UNPACK: begin
          r_s      <= r_a[31] ^ r_b[31];
          r_exp    <= $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd127;
          r_mb     <= {1'b1, r_b[22:0]};
          r_rem    <= {2'b01, r_a[22:0]};
          r_q      <= '0;
          r_cnt    <= '0;
          r_spec   <= w_spec;
          r_spec_z <= w_spec_z;
        end
        DIVIDE: begin
          r_q   <= {r_q[24:0], w_ge};
          r_rem <= w_rem_n << 1;
          r_cnt <= r_cnt + 5'd1;
        end
        NORM: begin
          if (!r_q[25]) begin
            r_q   <= {r_q[24:0], 1'b0};
            r_exp <= r_exp - 10'sd1;
          end
          r_st  <= |r_rem;
          r_cnt <= '0;
        end
        // Two ROUND cycles: round/renormalise, then range-check and pack
        ROUND: begin
          r_cnt <= r_cnt + 5'd1;
          if (!r_cnt[0]) begin
            r_mant <= w_sum[24] ? w_sum[23:1] : w_sum[22:0];
            r_exp  <= w_sum[24] ? r_exp + 10'sd1 : r_exp;
          end else r_z <= w_pack;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fdivider.sv
// tb_fdivider: scoreboard bench for fdivider; directed vectors, handshake/reset cases, 500 random pairs.
module tb_fdivider;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, in_ready, out_valid;
  logic [31:0] a, b, z;
`ifdef FDIVIDER_DBZ_EN
  logic        dbz;
`endif
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] q_z[$];
  logic        q_d[$];

  fdivider dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .z(z), .out_valid(out_valid),
`ifdef FDIVIDER_DBZ_EN
    .dbz(dbz),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] to_d(input logic [31:0] x);
    return {1'b0, 11'({3'b000, x[30:23]} + 11'd896), x[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    logic xz, yz, xi, yi, xn, yn, s;
    logic [63:0] qb;
    logic [23:0] m;
    logic [24:0] r;
    int e;
    xz = x[30:23] == 8'd0;
    yz = y[30:23] == 8'd0;
    xi = x[30:0] == 31'h7F800000;
    yi = y[30:0] == 31'h7F800000;
    xn = (x[30:23] == 8'hFF) && !xi;
    yn = (y[30:23] == 8'hFF) && !yi;
    s  = x[31] ^ y[31];
    if (xn || yn || (xz && yz) || (xi && yi)) return 32'h7FC00000;
    if (xi || yz) return {s, 8'hFF, 23'd0};
    if (xz || yi) return {s, 31'd0};
    qb = $realtobits($bitstoreal(to_d(x)) / $bitstoreal(to_d(y)));
    e  = int'(qb[62:52]) - 896;
    m  = {1'b1, qb[51:29]};
    r  = {1'b0, m} + {24'd0, qb[28] & ((|qb[27:0]) | m[0])};
    if (r[24]) e++;
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], r[24] ? r[23:1] : r[22:0]};
  endfunction

  function automatic logic ref_dbz(input logic [31:0] x, input logic [31:0] y);
    return (y[30:23] == 8'd0) && (x[30:23] != 8'd0) && (x[30:23] != 8'hFF);
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 11))
      0:       v[30:0] = 31'd0;
      1:       v[30:0] = 31'h7F800000;
      2:       v[30:23] = 8'hFF;
      3:       v[30:23] = 8'd0;
      default: v[30:23] = 8'($urandom_range(60, 194));
    endcase
    return v;
  endfunction

  // Drive one pair, push expectation, wait for result and check latency, z and dbz
  task automatic send(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                      input logic [31:0] ez, input logic ed);
    int n;
    logic [31:0] pz;
    logic pd;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " in_ready"}, {63'd0, in_ready}, 64'd1);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    q_z.push_back(ez);
    q_d.push_back(ed);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'd30);
    if (out_valid && q_z.size() > 0) begin
      pz = q_z.pop_front();
      pd = q_d.pop_front();
      chk({tag, " z"}, {32'd0, z}, {32'd0, pz});
`ifdef FDIVIDER_DBZ_EN
      chk({tag, " dbz"}, {63'd0, dbz}, {63'd0, pd});
`endif
    end else chk({tag, " result present"}, 64'd0, 64'd1);
    if (out_ready) @(negedge clk);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int hits;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    chk("reset z/ov/ir", {31'd0, out_valid, in_ready, z}, 64'd0);
`ifdef FDIVIDER_DBZ_EN
    chk("reset dbz", {63'd0, dbz}, 64'd0);
`endif
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready after reset", {63'd0, in_ready}, 64'd1);

    send("6/2",        32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    send("1/3",        32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0);
    send("-1/2",       32'hBF800000, 32'h40000000, 32'hBF000000, 1'b0);
    send("1/0",        32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1);
    send("0/0",        32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0);
    send("overflow",   32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0);
    send("underflow",  32'h00800000, 32'h40000000, 32'h00000000, 1'b0);
    send("inf/2",      32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0);
    send("-2/inf",     32'hC0000000, 32'h7F800000, 32'h80000000, 1'b0);
    send("nan/1",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0);
    send("inf/inf",    32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0);
    send("subn/1",     32'h00000001, 32'h3F800000, 32'h00000000, 1'b0);
    send("-0/2",       32'h80000000, 32'h40000000, 32'h80000000, 1'b0);
    send("-1/subn",    32'hBF800000, 32'h00000005, 32'hFF800000, 1'b1);

    out_ready = 1'b0;
    send("hold", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold ov/ir/z", {30'd0, out_valid, in_ready, z}, {30'd0, 2'b10, 32'h40400000});
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release ov/ir", {62'd0, out_valid, in_ready}, 64'd1);

    a = 32'h40C00000;
    b = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort outputs", {31'd0, out_valid, in_ready, z}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready after abort", {63'd0, in_ready}, 64'd1);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    chk("no out_valid for aborted pair", 64'(hits), 64'd0);
    send("after abort", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);

    for (int i = 0; i < 500; i++) begin
      ra = rnd_op();
      rb = rnd_op();
      send("random", ra, rb, ref_div(ra, rb), ref_dbz(ra, rb));
    end
    chk("scoreboard drained", 64'(q_z.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
